// File: rtl/pipelined_fp_adder.sv
// pipelined_fp_adder: IEEE-style add/subtract, subnormal inputs flushed to zero.
// Latency: 3 cycles (S1 unpack/compare/align, S2 mantissa add, S3 normalise/round/pack).
// Backpressure: all stages hold while out_valid & !out_ready; in_ready mirrors the advance enable.
// Build option FPADD_ROUND_NEAREST_EN: defined -> round to nearest even, undefined -> truncate.
module pipelined_fp_adder #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         op_sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] Sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   flags
);

  // Aligned mantissa: hidden bit, fraction, guard, round, sticky.
  localparam int FW  = MAN_W + 4;
  // Adder result: one extra carry bit on top.
  localparam int SW  = MAN_W + 5;
  // Working exponent: two extra bits so carry and negative results are visible.
  localparam int XW  = EXP_W + 2;
  localparam int LZW = $clog2(FW + 1);
  localparam logic [EXP_W-1:0] SH_LIM  = EXP_W'(MAN_W + 3);
  localparam logic [XW-1:0]    EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;

  // Stage registers
  logic             s1_vld_q, s1_nan_q, s1_inf_q, s1_sign_q, s1_sub_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [FW-1:0]    s1_ml_q, s1_ms_q;
  logic             s2_vld_q, s2_nan_q, s2_inf_q, s2_sign_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SW-1:0]    s2_sum_q;
  logic             out_vld_q;
  logic [W-1:0]     sum_q;
  logic [3:0]       flags_q;

  // Stage next-state values
  logic             s1_vld_d, s1_nan_d, s1_inf_d, s1_sign_d, s1_sub_d;
  logic [EXP_W-1:0] s1_exp_d;
  logic [FW-1:0]    s1_ml_d, s1_ms_d;
  logic             s2_vld_d, s2_nan_d, s2_inf_d, s2_sign_d;
  logic [EXP_W-1:0] s2_exp_d;
  logic [SW-1:0]    s2_sum_d;
  logic             out_vld_d;
  logic [W-1:0]     sum_d;
  logic [3:0]       flags_d;

  // S1 working signals
  logic             a_sign, b_sign, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic             swap, l_zero, s_zero;
  logic [EXP_W-1:0] a_exp, b_exp, l_exp, s_exp, shamt;
  logic [MAN_W-1:0] a_frac, b_frac, l_frac, s_frac;
  logic [W-2:0]     a_mag, b_mag;
  logic [FW-1:0]    s_ext, lost_mask;

  // S3 working signals
  logic [LZW-1:0]   lzc;
  logic [FW-1:0]    norm;
  logic [XW-1:0]    exp_n;
  logic [MAN_W-1:0] frac_o;
  logic             inexact, ovf, unf;
`ifdef FPADD_ROUND_NEAREST_EN
  logic             rnd_up;
  logic [MAN_W+1:0] mant_r;
`endif

  // One enable for the whole pipe: it only stalls when the output is full and not taken.
  assign advance   = !out_vld_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_vld_q;
  assign Sum       = sum_q;
  assign flags     = flags_q;

  // S1: unpack, classify, pick the larger magnitude, align the smaller one.
  always_comb begin
    a_sign = A[W-1];
    a_exp  = A[W-2:MAN_W];
    a_frac = A[MAN_W-1:0];
    b_sign = B[W-1] ^ op_sub;
    b_exp  = B[W-2:MAN_W];
    b_frac = B[MAN_W-1:0];

    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_nan  = (&a_exp) && (a_frac != '0);
    b_nan  = (&b_exp) && (b_frac != '0);
    a_inf  = (&a_exp) && (a_frac == '0);
    b_inf  = (&b_exp) && (b_frac == '0);

    // Subnormals compare as zero so they can never be chosen over a real zero.
    a_mag = a_zero ? '0 : A[W-2:0];
    b_mag = b_zero ? '0 : B[W-2:0];
    swap  = (b_mag > a_mag);

    l_exp  = swap ? b_exp  : a_exp;
    l_frac = swap ? b_frac : a_frac;
    l_zero = swap ? b_zero : a_zero;
    s_exp  = swap ? a_exp  : b_exp;
    s_frac = swap ? a_frac : b_frac;
    s_zero = swap ? a_zero : b_zero;

    shamt     = l_exp - s_exp;
    s_ext     = s_zero ? '0 : {1'b1, s_frac, 3'b000};
    lost_mask = ~({FW{1'b1}} << shamt);

    // Anything shifted past the sticky position collapses into the sticky bit.
    if (shamt >= SH_LIM) begin
      s1_ms_d = {{(FW-1){1'b0}}, |s_ext};
    end else begin
      s1_ms_d = (s_ext >> shamt) | {{(FW-1){1'b0}}, |(s_ext & lost_mask)};
    end

    s1_ml_d   = l_zero ? '0 : {1'b1, l_frac, 3'b000};
    s1_exp_d  = l_exp;
    s1_sign_d = swap ? b_sign : a_sign;
    s1_sub_d  = a_sign ^ b_sign;
    // An infinity always wins the magnitude compare, so s1_sign_d is its sign.
    s1_nan_d  = a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign));
    s1_inf_d  = a_inf || b_inf;
    s1_vld_d  = in_valid;
  end

  // S1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_nan_q  <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_sub_q  <= 1'b0;
      s1_exp_q  <= '0;
      s1_ml_q   <= '0;
      s1_ms_q   <= '0;
    end else if (advance) begin
      s1_vld_q  <= s1_vld_d;
      s1_nan_q  <= s1_nan_d;
      s1_inf_q  <= s1_inf_d;
      s1_sign_q <= s1_sign_d;
      s1_sub_q  <= s1_sub_d;
      s1_exp_q  <= s1_exp_d;
      s1_ml_q   <= s1_ml_d;
      s1_ms_q   <= s1_ms_d;
    end
  end

  // S2: magnitude add or subtract; larger minus smaller is never negative.
  always_comb begin
    if (s1_sub_q) begin
      s2_sum_d = {1'b0, s1_ml_q} - {1'b0, s1_ms_q};
    end else begin
      s2_sum_d = {1'b0, s1_ml_q} + {1'b0, s1_ms_q};
    end
    s2_vld_d  = s1_vld_q;
    s2_nan_d  = s1_nan_q;
    s2_inf_d  = s1_inf_q;
    s2_sign_d = s1_sign_q;
    s2_exp_d  = s1_exp_q;
  end

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_nan_q  <= 1'b0;
      s2_inf_q  <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_sum_q  <= '0;
    end else if (advance) begin
      s2_vld_q  <= s2_vld_d;
      s2_nan_q  <= s2_nan_d;
      s2_inf_q  <= s2_inf_d;
      s2_sign_q <= s2_sign_d;
      s2_exp_q  <= s2_exp_d;
      s2_sum_q  <= s2_sum_d;
    end
  end

  // S3: normalise, round, then resolve specials and range into the packed result.
  always_comb begin
    lzc = '0;
    for (int i = 0; i < FW; i++) begin
      if (s2_sum_q[i]) lzc = LZW'(FW - 1 - i);
    end

    if (s2_sum_q[SW-1]) begin
      // Carry out: shift right one, folding the dropped bit into sticky.
      norm  = s2_sum_q[SW-1:1] | {{(FW-1){1'b0}}, s2_sum_q[0]};
      exp_n = XW'(s2_exp_q) + XW'(1);
    end else begin
      norm  = s2_sum_q[FW-1:0] << lzc;
      exp_n = XW'(s2_exp_q) - XW'(lzc);
    end

    inexact = |norm[2:0];

`ifdef FPADD_ROUND_NEAREST_EN
    // Round up above half, or at exactly half when the kept LSB is odd.
    rnd_up = norm[2] && (norm[1] || norm[0] || norm[3]);
    mant_r = {1'b0, norm[FW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    if (mant_r[MAN_W+1]) begin
      frac_o = mant_r[MAN_W:1];
      exp_n  = exp_n + XW'(1);
    end else begin
      frac_o = mant_r[MAN_W-1:0];
    end
`else
    frac_o = norm[FW-2:3];
`endif

    ovf = !exp_n[XW-1] && (exp_n >= EXP_MAX);
    unf = exp_n[XW-1] || (exp_n == '0);

    out_vld_d = s2_vld_q;
    sum_d     = '0;
    flags_d   = '0;
    if (s2_nan_q) begin
      sum_d   = QNAN;
      flags_d = 4'b1000;
    end else if (s2_inf_q) begin
      sum_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (!norm[FW-1]) begin
      // No leading one after normalising: exact cancellation or both zero -> +0.
      sum_d   = '0;
    end else if (ovf) begin
      sum_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (unf) begin
      // A nonzero value is flushed to zero, so the result is also inexact.
      sum_d   = {s2_sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else begin
      sum_d   = {s2_sign_q, exp_n[EXP_W-1:0], frac_o};
      flags_d = {3'b000, inexact};
    end
  end

  // Output register: Sum and flags stay put while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      sum_q     <= '0;
      flags_q   <= '0;
    end else if (advance) begin
      out_vld_q <= out_vld_d;
      sum_q     <= sum_d;
      flags_q   <= flags_d;
    end
  end

endmodule
